// File: rtl/uart_setpoint_rx.sv
// Purpose: 8N1 UART receiver that decodes A5/XL/XH/YL/YH/CK packets into X/Y setpoints.
// Latency: 2-clk input sync; set_x/set_y/set_valid update the clk after the CK stop-bit sample.
// Backpressure: none; the serial line cannot be stalled, so all status outputs are 1-clk pulses.
module uart_setpoint_rx #(
    parameter int          CLKS_PER_BIT = 434,
    parameter int          TIMEOUT_BITS = 20,
    parameter logic [15:0] SET_X_INIT   = 16'd0,
    parameter logic [15:0] SET_Y_INIT   = 16'd0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        rx_in,
    output logic [15:0] set_x,
    output logic [15:0] set_y,
    output logic        set_valid,
    output logic        frame_err,
    output logic        csum_err
);

    localparam int BT_W   = $clog2(CLKS_PER_BIT);
    localparam int TO_MAX = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TO_W   = $clog2(TO_MAX + 1);
    localparam logic [BT_W-1:0] BT_HALF = BT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BT_W-1:0] BT_LAST = BT_W'(CLKS_PER_BIT - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_MAX - 1);

    typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bstate_t;
    typedef enum logic [2:0] {P_SYNC, P_XL, P_XH, P_YL, P_YH, P_CK} pstate_t;

    logic            r_rx_meta, r_rx_s;
    bstate_t         r_bstate, w_bstate_nxt;
    logic [BT_W-1:0] r_btmr, w_btmr_nxt;
    logic [2:0]      r_bidx, w_bidx_nxt;
    logic [7:0]      r_bshift, w_bshift_nxt;
    logic            w_byte_rdy, w_frame_err;

    pstate_t         r_pstate, w_pstate_nxt;
    logic [TO_W-1:0] r_to_cnt, w_to_nxt;
    logic            w_timeout, w_load, w_csum_bad;
    logic [7:0]      r_xl, r_xh, r_yl, r_yh;
    logic [15:0]     r_set_x, r_set_y;
    logic            r_set_valid, r_frame_err, r_csum_err;

    assign set_x     = r_set_x;
    assign set_y     = r_set_y;
    assign set_valid = r_set_valid;
    assign frame_err = r_frame_err;
    assign csum_err  = r_csum_err;

    // Two-flop synchronizer; presets to idle-high so reset never looks like a start bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx_in;
            r_rx_s    <= r_rx_meta;
        end
    end

    // Byte FSM state, bit timer, bit index and data register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bstate <= B_IDLE;
            r_btmr   <= '0;
            r_bidx   <= '0;
            r_bshift <= '0;
        end else begin
            r_bstate <= w_bstate_nxt;
            r_btmr   <= w_btmr_nxt;
            r_bidx   <= w_bidx_nxt;
            r_bshift <= w_bshift_nxt;
        end
    end

    // Byte FSM next state: start-bit qualification at mid-bit, then one sample per bit period.
    always_comb begin
        w_bstate_nxt = r_bstate;
        w_btmr_nxt   = r_btmr + 1'b1;
        w_bidx_nxt   = r_bidx;
        w_bshift_nxt = r_bshift;
        w_byte_rdy   = 1'b0;
        w_frame_err  = 1'b0;
        case (r_bstate)
            B_IDLE: begin
                w_btmr_nxt = '0;
                if (!r_rx_s) w_bstate_nxt = B_START;
            end
            B_START: begin
                if (r_btmr == BT_HALF) begin
                    w_btmr_nxt   = '0;
                    w_bidx_nxt   = '0;
                    w_bstate_nxt = r_rx_s ? B_IDLE : B_DATA;
                end
            end
            B_DATA: begin
                if (r_btmr == BT_LAST) begin
                    w_btmr_nxt           = '0;
                    w_bshift_nxt[r_bidx] = r_rx_s;
                    if (r_bidx == 3'd7) w_bstate_nxt = B_STOP;
                    else                w_bidx_nxt   = r_bidx + 3'd1;
                end
            end
            B_STOP: begin
                // Re-arm at mid stop bit so back-to-back bytes are never missed.
                if (r_btmr == BT_LAST) begin
                    w_btmr_nxt   = '0;
                    w_bstate_nxt = B_IDLE;
                    if (r_rx_s) w_byte_rdy  = 1'b1;
                    else        w_frame_err = 1'b1;
                end
            end
            default: w_bstate_nxt = B_IDLE;
        endcase
    end

    // Packet FSM state and inter-byte timeout counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pstate <= P_SYNC;
            r_to_cnt <= '0;
        end else begin
            r_pstate <= w_pstate_nxt;
            r_to_cnt <= w_to_nxt;
        end
    end

    // Packet FSM next state: framing errors and timeouts both abandon the packet silently.
    always_comb begin
        w_pstate_nxt = r_pstate;
        w_to_nxt     = r_to_cnt;
        w_load       = 1'b0;
        w_csum_bad   = 1'b0;
        w_timeout    = (r_pstate != P_SYNC) && (r_bstate == B_IDLE) && (r_to_cnt == TO_LAST);
        if (r_pstate == P_SYNC || w_byte_rdy) w_to_nxt = '0;
        else if (r_bstate == B_IDLE)          w_to_nxt = r_to_cnt + 1'b1;
        if (w_frame_err) begin
            w_pstate_nxt = P_SYNC;
        end else if (w_timeout) begin
            w_pstate_nxt = P_SYNC;
            w_to_nxt     = '0;
        end else if (w_byte_rdy) begin
            case (r_pstate)
                P_SYNC: if (r_bshift == 8'hA5) w_pstate_nxt = P_XL;
                P_XL:   w_pstate_nxt = P_XH;
                P_XH:   w_pstate_nxt = P_YL;
                P_YL:   w_pstate_nxt = P_YH;
                P_YH:   w_pstate_nxt = P_CK;
                P_CK: begin
                    if (r_bshift == (r_xl ^ r_xh ^ r_yl ^ r_yh)) w_load     = 1'b1;
                    else                                         w_csum_bad = 1'b1;
                    w_pstate_nxt = P_SYNC;
                end
                default: w_pstate_nxt = P_SYNC;
            endcase
        end
    end

    // Shadow capture of payload bytes; setpoints load atomically only on a checksum match.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_xl        <= '0;
            r_xh        <= '0;
            r_yl        <= '0;
            r_yh        <= '0;
            r_set_x     <= SET_X_INIT;
            r_set_y     <= SET_Y_INIT;
            r_set_valid <= 1'b0;
            r_frame_err <= 1'b0;
            r_csum_err  <= 1'b0;
        end else begin
            if (w_byte_rdy && !w_timeout) begin
                case (r_pstate)
                    P_XL:    r_xl <= r_bshift;
                    P_XH:    r_xh <= r_bshift;
                    P_YL:    r_yl <= r_bshift;
                    P_YH:    r_yh <= r_bshift;
                    default: ;
                endcase
            end
            if (w_load) begin
                r_set_x <= {r_xh, r_xl};
                r_set_y <= {r_yh, r_yl};
            end
            r_set_valid <= w_load;
            r_frame_err <= w_frame_err;
            r_csum_err  <= w_csum_bad;
        end
    end

endmodule

// File: tb/tb_uart_setpoint_rx.sv
// Purpose: randomized and directed bench for uart_setpoint_rx with a packet-level reference model.
// Latency: expected events are queued when each byte is sent; the monitor matches DUT pulses in order.
// Backpressure: none; the serial stimulus free-runs and the monitor samples on the falling edge.
module tb_uart_setpoint_rx;

    localparam int          CPB    = 16;
    localparam int          TOBITS = 20;
    localparam logic [15:0] XINIT  = 16'd0;
    localparam logic [15:0] YINIT  = 16'd0;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        rx_in = 1'b1;
    logic [15:0] set_x, set_y;
    logic        set_valid, frame_err, csum_err;

    uart_setpoint_rx #(
        .CLKS_PER_BIT(CPB),
        .TIMEOUT_BITS(TOBITS),
        .SET_X_INIT  (XINIT),
        .SET_Y_INIT  (YINIT)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .rx_in    (rx_in),
        .set_x    (set_x),
        .set_y    (set_y),
        .set_valid(set_valid),
        .frame_err(frame_err),
        .csum_err (csum_err)
    );

    always #5 clk = ~clk;

    // kind: 0 = set_valid with x/y, 1 = csum_err, 2 = frame_err
    typedef struct {
        int          kind;
        logic [15:0] x;
        logic [15:0] y;
    } ev_t;

    ev_t         exp_q[$];
    int          n_tests = 0;
    int          n_fail = 0;
    int          mon_events = 0;

    // Reference model: position within a packet plus the received payload bytes.
    int          m_pos = 0;
    logic [7:0]  m_buf[5];
    logic [15:0] m_x = XINIT;
    logic [15:0] m_y = YINIT;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void model_byte(input logic [7:0] b, input bit stop_ok, input bit timed_out);
        ev_t e;
        e.x = '0;
        e.y = '0;
        if (timed_out) m_pos = 0;
        if (!stop_ok) begin
            e.kind = 2;
            exp_q.push_back(e);
            m_pos = 0;
            return;
        end
        if (m_pos == 0) begin
            if (b == 8'hA5) m_pos = 1;
            return;
        end
        m_buf[m_pos-1] = b;
        m_pos++;
        if (m_pos == 6) begin
            m_pos = 0;
            if ((m_buf[0] ^ m_buf[1] ^ m_buf[2] ^ m_buf[3]) == m_buf[4]) begin
                m_x    = {m_buf[1], m_buf[0]};
                m_y    = {m_buf[3], m_buf[2]};
                e.kind = 0;
                e.x    = m_x;
                e.y    = m_y;
            end else begin
                e.kind = 1;
            end
            exp_q.push_back(e);
        end
    endfunction

    // Called at a falling edge; drives one bit period.
    task automatic drive_bit(input logic v);
        rx_in = v;
        repeat (CPB) @(negedge clk);
    endtask

    // gap_bits of idle line precede the frame; gaps are either <= 2 or > TOBITS bits.
    task automatic send_byte(input logic [7:0] b, input bit stop_ok, input int gap_bits);
        drive_bit_idle(gap_bits);
        model_byte(b, stop_ok, gap_bits > TOBITS);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_ok);
        rx_in = 1'b1;
        if (!stop_ok) repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic drive_bit_idle(input int nbits);
        rx_in = 1'b1;
        repeat (nbits * CPB) @(negedge clk);
    endtask

    task automatic send_packet(input logic [15:0] x, input logic [15:0] y, input logic [7:0] ck_flip);
        logic [7:0] ck;
        ck = x[7:0] ^ x[15:8] ^ y[7:0] ^ y[15:8] ^ ck_flip;
        send_byte(8'hA5,   1'b1, $urandom_range(0, 2));
        send_byte(x[7:0],  1'b1, $urandom_range(0, 2));
        send_byte(x[15:8], 1'b1, $urandom_range(0, 2));
        send_byte(y[7:0],  1'b1, $urandom_range(0, 2));
        send_byte(y[15:8], 1'b1, $urandom_range(0, 2));
        send_byte(ck,      1'b1, $urandom_range(0, 2));
    endtask

    task automatic check_state(input string tag);
        repeat (4) @(negedge clk);
        check({tag, "_set_x"}, {16'd0, set_x}, {16'd0, m_x});
        check({tag, "_set_y"}, {16'd0, set_y}, {16'd0, m_y});
        check({tag, "_pending"}, exp_q.size(), 0);
    endtask

    // Monitor: every DUT pulse must match the oldest expected event.
    ev_t mon_e;
    int  mon_kind;
    always @(negedge clk) begin
        if (reset_n && (set_valid || csum_err || frame_err)) begin
            mon_events++;
            mon_kind = set_valid ? 0 : (csum_err ? 1 : 2);
            n_tests++;
            if ((32'(set_valid) + 32'(csum_err) + 32'(frame_err)) != 1) begin
                n_fail++;
                $display("FAIL pulse_exclusive: valid=%b csum=%b frame=%b", set_valid, csum_err, frame_err);
            end else if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_event: got kind %0d, expected no event", mon_kind);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_kind != mon_e.kind) begin
                    n_fail++;
                    $display("FAIL event_kind: got %0d expected %0d", mon_kind, mon_e.kind);
                end else if (mon_kind == 0) begin
                    n_tests++;
                    if (set_x !== mon_e.x || set_y !== mon_e.y) begin
                        n_fail++;
                        $display("FAIL setpoint: got x=%h y=%h expected x=%h y=%h",
                                 set_x, set_y, mon_e.x, mon_e.y);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    initial begin
        int          ev0;
        int          mode;
        int          k;
        logic [15:0] rx, ry;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_set_x", {16'd0, set_x}, {16'd0, XINIT});
        check("rst_set_y", {16'd0, set_y}, {16'd0, YINIT});
        check("rst_pulses", {29'd0, set_valid, frame_err, csum_err}, 32'd0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        // 1: valid packet
        send_packet(16'h1234, 16'h5678, 8'h00);
        check_state("t1");
        // 2: bad checksum
        send_packet(16'h4321, 16'h8765, 8'h5C);
        check_state("t2");
        // 3: framing error inside a packet, then recovery
        send_byte(8'hA5, 1'b1, 1);
        send_byte(8'h34, 1'b0, 1);
        send_packet(16'h0001, 16'h0002, 8'h00);
        check_state("t3");
        // 4: inter-byte timeout drops the partial packet
        send_byte(8'hA5, 1'b1, 1);
        send_byte(8'h34, 1'b1, 0);
        send_byte(8'h12, 1'b1, 0);
        send_byte(8'h78, 1'b1, TOBITS + 1);
        send_byte(8'h56, 1'b1, 0);
        send_byte(8'h6A, 1'b1, 0);
        check_state("t4a");
        send_packet(16'hFFFF, 16'h8000, 8'h00);
        check_state("t4b");
        // 5: short glitch while idle, then reset mid-packet
        ev0 = mon_events;
        rx_in = 1'b0;
        repeat (4) @(negedge clk);
        rx_in = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        check("glitch_no_event", mon_events, ev0);
        check_state("t5a");
        send_byte(8'hA5, 1'b1, 1);
        send_byte(8'h34, 1'b1, 0);
        send_byte(8'h12, 1'b1, 0);
        repeat (CPB) @(negedge clk);
        reset_n = 1'b0;
        check("pending_before_reset", exp_q.size(), 0);
        m_pos = 0;
        m_x = XINIT;
        m_y = YINIT;
        repeat (2) @(negedge clk);
        check("rst2_set_x", {16'd0, set_x}, {16'd0, XINIT});
        check("rst2_set_y", {16'd0, set_y}, {16'd0, YINIT});
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        send_packet(16'hBEEF, 16'h0BAD, 8'h00);
        check_state("t5b");
        // 6: garbage then a packet whose payload contains 0xA5
        send_byte(8'h00, 1'b1, 1);
        send_byte(8'hFF, 1'b1, 0);
        send_byte(8'h5A, 1'b1, 0);
        send_packet(16'hA5A5, 16'h0000, 8'h00);
        check_state("t6");

        // Randomized packets with assorted faults
        for (int it = 0; it < 24; it++) begin
            rx = 16'($urandom);
            ry = 16'($urandom);
            if ($urandom_range(0, 3) == 0) rx[7:0] = 8'hA5;
            mode = $urandom_range(0, 4);
            case (mode)
                0: send_packet(rx, ry, 8'h00);
                1: send_packet(rx, ry, 8'($urandom_range(1, 255)));
                2, 3: begin
                    k = $urandom_range(1, 5);
                    send_byte(8'hA5, 1'b1, 1);
                    for (int j = 1; j < 6; j++) begin
                        logic [7:0] b;
                        b = (j == 1) ? rx[7:0] : (j == 2) ? rx[15:8] :
                            (j == 3) ? ry[7:0] : (j == 4) ? ry[15:8] :
                            (rx[7:0] ^ rx[15:8] ^ ry[7:0] ^ ry[15:8]);
                        if (mode == 2) send_byte(b, j != k, 0);
                        else           send_byte(b, 1'b1, (j == k) ? TOBITS + 1 : 0);
                    end
                end
                default: begin
                    for (int j = 0; j < 3; j++) send_byte(8'($urandom), 1'b1, 1);
                    send_packet(rx, ry, 8'h00);
                end
            endcase
            check_state("rand");
        end

        repeat (3 * CPB) @(negedge clk);
        check("final_pending", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
